tap_addr_gen: RTL and testbench
===============================

TAP_ADDR_GEN -- requirements
Module: tap_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the address width; the buffer depth is DEPTH = 2^ADDR_W.
REQ-002 Parameter NCH, default 2, SHALL set the number of channels processed per run (range 1..16).
REQ-003 Derived width CH_W SHALL be max(1, clog2(NCH)).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 cfg_we  in  1  load cfg_taps into the tap-count register.
REQ-008 cfg_taps  in  ADDR_W+1  requested tap count.
REQ-009 smp_push  in  1  new sample written; advances the write pointer.
REQ-010 start  in  1  begin a run.
REQ-011 abort  in  1  terminate the current run.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 addr_valid  out  1  coef_addr, smp_addr, ch and last are valid this cycle.
REQ-014 coef_addr  out  ADDR_W  coefficient index.
REQ-015 smp_addr  out  ADDR_W  circular sample-buffer index.
REQ-016 ch  out  CH_W  current channel.
REQ-017 last  out  1  final tap of the current channel.
REQ-018 done  out  1  one-cycle pulse marking run completion.
REQ-019 head  out  ADDR_W  current write pointer.

Function
REQ-020 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-021 When cfg_we is high in IDLE, taps SHALL load cfg_taps clamped to 1..DEPTH (0 becomes 1; values above DEPTH become DEPTH).
REQ-022 cfg_we SHALL be ignored while busy is high.
REQ-023 Each smp_push SHALL advance head to head+1 mod DEPTH in every state, including during a run.
REQ-024 A start in IDLE SHALL cause a transition to RUN on the next edge and SHALL clear tap and ch to 0.
REQ-025 On that same start, base SHALL capture head, including the effect of any smp_push in that cycle.
REQ-026 When cfg_we and start are high in the same IDLE cycle, the run SHALL use the newly loaded tap count.
REQ-027 start SHALL be ignored while busy is high.
REQ-028 In RUN, addr_valid SHALL be 1, coef_addr SHALL equal tap, and smp_addr SHALL equal (base - tap) mod DEPTH.
REQ-029 All outputs SHALL be driven from registers only, with no combinational path from any input.
REQ-030 In RUN, last SHALL be 1 exactly when tap = taps-1.
REQ-031 On a last cycle, tap SHALL wrap to 0 and ch SHALL increment.
REQ-032 If last is high and ch = NCH-1, the next state SHALL be DONE and ch SHALL return to 0.
REQ-033 A run SHALL occupy exactly taps*NCH RUN cycles, with the first addr_valid one cycle after start.
REQ-034 In DONE, done SHALL be high for one cycle and addr_valid SHALL be 0; the next state SHALL be IDLE.
REQ-035 A new start SHALL be accepted no earlier than one cycle after DONE.
REQ-036 With taps = 1, last SHALL be high on every RUN cycle.
REQ-037 With taps = DEPTH, smp_addr SHALL cover every buffer entry exactly once per channel.
REQ-038 abort in RUN or DONE SHALL force IDLE on the next edge with no done pulse and SHALL clear tap and ch; abort has priority over all other inputs.
REQ-039 abort in IDLE SHALL have no effect.
REQ-040 Subtractions SHALL wrap modulo DEPTH, and the tap counter width SHALL be ADDR_W+1 so that tap never overflows before last.

Reset
REQ-041 On rst, the block SHALL asynchronously force: state IDLE; tap, ch, base and head to 0; taps to DEPTH; busy, addr_valid, last and done to 0; coef_addr and smp_addr to 0.
REQ-042 Reset asserted mid-run SHALL abandon the run immediately, with no done pulse.
REQ-043 After rst deasserts, the block SHALL accept start on the first clock edge.

Verification
REQ-044 Bench SHALL check the defaults after reset: ADDR_W=5, NCH=2, taps=32, start -> 64 valid cycles with coef_addr 0..31 twice, smp_addr 0,31,30..1, last at cycles 32 and 64, done at cycle 65.
REQ-045 Bench SHALL check a short run: cfg_taps=4, then 6 pushes (head=6), then start -> per channel smp_addr 6,5,4,3 and coef_addr 0..3, ch 0 then 1, done at cycle 9.
REQ-046 Bench SHALL check clamping: cfg_taps=0 -> one-tap run, last on every cycle, done after NCH cycles; cfg_taps=40 -> taps=32.
REQ-047 Bench SHALL check abort: abort at the 10th RUN cycle -> busy=0 on the next cycle and no done; a following start restarts at tap 0, ch 0.
REQ-048 Bench SHALL check simultaneous events: cfg_we+start+smp_push in one IDLE cycle -> the new taps are used and base = head+1; a push during the run changes head but not smp_addr; start/cfg_we during busy are ignored.
REQ-049 Bench SHALL check reset mid-run: rst pulse at RUN cycle 5 -> all outputs 0 immediately, taps=32, head=0.

Source files
------------

// File: rtl/tap_addr_gen.sv
// -----------------------------------------------------------------------------
// tap_addr_gen
//
// Address generator for a multi-channel FIR engine built around a circular
// sample buffer. Each run sweeps every channel through `taps` coefficients.
// On each RUN cycle it presents the coefficient index and the matching sample
// index, walking backwards from the write pointer that was captured at start.
// The write pointer (head) advances on every sample push, so the buffer keeps
// filling while a run is in progress.
//
// Parameters
//   ADDR_W  address width; the buffer depth is DEPTH = 2**ADDR_W
//   NCH     channels processed per run (1..16)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   cfg_we      load cfg_taps into the tap-count register (IDLE only)
//   cfg_taps    requested tap count, clamped to 1..DEPTH
//   smp_push    a new sample was written; advances head
//   start       begin a run (IDLE only)
//   abort       abandon the current run (RUN/DONE only)
//   busy        state is not IDLE
//   addr_valid  coef_addr, smp_addr, ch and last are valid
//   coef_addr   coefficient index (the current tap)
//   smp_addr    circular sample index, base - tap mod DEPTH
//   ch          current channel
//   last        final tap of the current channel
//   done        one-cycle pulse on run completion
//   head        current write pointer
//
// All outputs come straight from flops. The next-state logic also computes
// the next output values, so the first valid address appears on the cycle
// right after start.
// -----------------------------------------------------------------------------
module tap_addr_gen #(
    parameter int ADDR_W = 5,
    parameter int NCH    = 2,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W:0]   cfg_taps,
    input  logic              smp_push,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [ADDR_W-1:0] smp_addr,
    output logic [CH_W-1:0]   ch,
    output logic              last,
    output logic              done,
    output logic [ADDR_W-1:0] head
);

    // The tap counter and tap-count register are one bit wider than an
    // address, so that DEPTH itself can be represented.
    localparam int              TW      = ADDR_W + 1;
    localparam logic [TW-1:0]   DEPTH_V = TW'(1) << ADDR_W;
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state,  w_state_nxt;
    logic [TW-1:0]     r_taps,   w_taps_nxt;
    logic [TW-1:0]     r_tap,    w_tap_nxt;
    logic [CH_W-1:0]   r_ch,     w_ch_nxt;
    logic [ADDR_W-1:0] r_base,   w_base_nxt;
    logic [ADDR_W-1:0] r_head,   w_head_nxt;

    logic              r_busy,       w_busy_nxt;
    logic              r_addr_valid, w_addr_valid_nxt;
    logic [ADDR_W-1:0] r_coef_addr,  w_coef_addr_nxt;
    logic [ADDR_W-1:0] r_smp_addr,   w_smp_addr_nxt;
    logic              r_last,       w_last_nxt;
    logic              r_done,       w_done_nxt;

    logic              w_tap_last;

    // Map a requested tap count into the legal range 1..DEPTH.
    function automatic logic [TW-1:0] clamp_taps(input logic [TW-1:0] v);
        if (v == '0)
            return TW'(1);
        else if (v > DEPTH_V)
            return DEPTH_V;
        else
            return v;
    endfunction

    // The write pointer runs in every state and wraps naturally at DEPTH.
    assign w_head_nxt = r_head + ADDR_W'(smp_push);
    assign w_tap_last = (r_tap == r_taps - TW'(1));

    // Next-state and next-output logic.
    // NOTE: every signal gets a default at the top of the block, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_taps_nxt  = r_taps;
        w_tap_nxt   = r_tap;
        w_ch_nxt    = r_ch;
        w_base_nxt  = r_base;

        unique case (r_state)
            S_IDLE: begin
                if (cfg_we)
                    w_taps_nxt = clamp_taps(cfg_taps);
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_tap_nxt   = '0;
                    w_ch_nxt    = '0;
                    // Base includes a push that happens in the start cycle.
                    w_base_nxt  = w_head_nxt;
                end
            end
            S_RUN: begin
                if (w_tap_last) begin
                    w_tap_nxt = '0;
                    if (r_ch == CH_LAST) begin
                        w_ch_nxt    = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ch_nxt = r_ch + CH_W'(1);
                    end
                end else begin
                    w_tap_nxt = r_tap + TW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything, but only once a run has started.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_tap_nxt   = '0;
            w_ch_nxt    = '0;
        end

        // Outputs for the coming cycle, derived from the next-state values.
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_addr_valid_nxt = (w_state_nxt == S_RUN);
        w_done_nxt       = (w_state_nxt == S_DONE);
        w_coef_addr_nxt  = '0;
        w_smp_addr_nxt   = '0;
        w_last_nxt       = 1'b0;
        if (w_state_nxt == S_RUN) begin
            // The tap is always below DEPTH in RUN, so the low bits suffice.
            w_coef_addr_nxt = w_tap_nxt[ADDR_W-1:0];
            w_smp_addr_nxt  = w_base_nxt - w_tap_nxt[ADDR_W-1:0];
            w_last_nxt      = (w_tap_nxt == w_taps_nxt - TW'(1));
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments, so every
    // flop samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_taps       <= DEPTH_V;
            r_tap        <= '0;
            r_ch         <= '0;
            r_base       <= '0;
            r_head       <= '0;
            r_busy       <= 1'b0;
            r_addr_valid <= 1'b0;
            r_coef_addr  <= '0;
            r_smp_addr   <= '0;
            r_last       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_taps       <= w_taps_nxt;
            r_tap        <= w_tap_nxt;
            r_ch         <= w_ch_nxt;
            r_base       <= w_base_nxt;
            r_head       <= w_head_nxt;
            r_busy       <= w_busy_nxt;
            r_addr_valid <= w_addr_valid_nxt;
            r_coef_addr  <= w_coef_addr_nxt;
            r_smp_addr   <= w_smp_addr_nxt;
            r_last       <= w_last_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign busy       = r_busy;
    assign addr_valid = r_addr_valid;
    assign coef_addr  = r_coef_addr;
    assign smp_addr   = r_smp_addr;
    assign ch         = r_ch;
    assign last       = r_last;
    assign done       = r_done;
    assign head       = r_head;

endmodule

// File: tb/tb_tap_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_tap_addr_gen
//
// Directed bench for tap_addr_gen at its default parameters (ADDR_W=5, NCH=2).
// Whenever a run is started, the bench pushes the address sequence it expects
// onto a queue, built from its own model of the write pointer. Each valid
// output cycle pops one entry and compares it against the outputs.
// -----------------------------------------------------------------------------
module tb_tap_addr_gen;

    localparam int ADDR_W = 5;
    localparam int NCH    = 2;
    localparam int CH_W   = 1;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [ADDR_W:0]   cfg_taps;
    logic              smp_push;
    logic              start;
    logic              abort;
    logic              busy;
    logic              addr_valid;
    logic [ADDR_W-1:0] coef_addr;
    logic [ADDR_W-1:0] smp_addr;
    logic [CH_W-1:0]   ch;
    logic              last;
    logic              done;
    logic [ADDR_W-1:0] head;

    always #5 clk = ~clk;

    tap_addr_gen #(
        .ADDR_W (ADDR_W),
        .NCH    (NCH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_taps   (cfg_taps),
        .smp_push   (smp_push),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .addr_valid (addr_valid),
        .coef_addr  (coef_addr),
        .smp_addr   (smp_addr),
        .ch         (ch),
        .last       (last),
        .done       (done),
        .head       (head)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] coef;
        logic [ADDR_W-1:0] smp;
        logic [CH_W-1:0]   ch;
        logic              last;
    } exp_t;

    exp_t              sb_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                g_nv;
    int                g_cyc;
    int                g_done_cyc;
    logic [ADDR_W-1:0] m_head;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge. All strobes are single-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        start    = 1'b0;
        cfg_we   = 1'b0;
        smp_push = 1'b0;
        abort    = 1'b0;
    endtask

    task automatic push_sample();
        smp_push = 1'b1;
        m_head   = m_head + 1'b1;
        tick();
    endtask

    // Queue the expected address sequence for one run, then issue start.
    // Any cfg_we / smp_push the caller set up goes out in the same cycle.
    task automatic start_run(input logic [ADDR_W-1:0] base, input int taps);
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            for (int t = 0; t < taps; t++) begin
                e.coef = ADDR_W'(t);
                e.smp  = base - ADDR_W'(t);
                e.ch   = CH_W'(c);
                e.last = (t == taps - 1);
                sb_q.push_back(e);
            end
        end
        start = 1'b1;
        tick();
        g_nv       = 0;
        g_cyc      = 1;
        g_done_cyc = 0;
    endtask

    // Follow a run cycle by cycle. With stop_after > 0, return on the cycle
    // that produced that many valid outputs; resume = 1 continues from there.
    task automatic watch_run(input string tag, input int n_exp, input int stop_after, input bit resume);
        exp_t e;
        if (resume) begin
            tick();
            g_cyc++;
        end
        while (g_cyc <= n_exp + 4) begin
            check($sformatf("%s head c%0d", tag, g_cyc), 32'(head), 32'(m_head));
            check($sformatf("%s busy c%0d", tag, g_cyc), 32'(busy), 32'(1));
            if (addr_valid) begin
                g_nv++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check($sformatf("%s out#%0d {coef,smp,ch,last}", tag, g_nv),
                          32'({coef_addr, smp_addr, ch, last}), 32'(e));
                end
            end
            if (done) begin
                g_done_cyc = g_cyc;
                check($sformatf("%s addr_valid at done", tag), 32'(addr_valid), 32'(0));
                break;
            end
            if ((stop_after != 0) && (g_nv == stop_after))
                return;
            tick();
            g_cyc++;
        end
        check($sformatf("%s valid count", tag), 32'(g_nv), 32'(n_exp));
        check($sformatf("%s done cycle", tag), 32'(g_done_cyc), 32'(n_exp + 1));
        check($sformatf("%s scoreboard left", tag), 32'(sb_q.size()), 32'(0));
        tick();
        check($sformatf("%s idle after done {done,busy,valid}", tag),
              32'({done, busy, addr_valid}), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_taps = '0;
        smp_push = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        m_head   = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 32'({busy, addr_valid, coef_addr, smp_addr, ch, last, done, head}), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Default run straight out of reset: 32 taps x 2 channels from head 0.
        start_run(m_head, DEPTH);
        watch_run("default", DEPTH * NCH, 0, 1'b0);

        // Short run: 4 taps after six pushes.
        cfg_we   = 1'b1;
        cfg_taps = 6'd4;
        tick();
        repeat (6) push_sample();
        check("head after 6 pushes", 32'(head), 32'(6));
        start_run(m_head, 4);
        watch_run("short", 4 * NCH, 0, 1'b0);

        // Clamp low: 0 becomes a one-tap run, last on every cycle.
        cfg_we   = 1'b1;
        cfg_taps = 6'd0;
        tick();
        start_run(m_head, 1);
        watch_run("clamp0", NCH, 0, 1'b0);

        // Clamp high: 40 becomes DEPTH.
        cfg_we   = 1'b1;
        cfg_taps = 6'd40;
        tick();
        start_run(m_head, DEPTH);
        watch_run("clamp40", DEPTH * NCH, 0, 1'b0);

        // Abort on the 10th RUN cycle.
        start_run(m_head, DEPTH);
        watch_run("abort", DEPTH * NCH, 10, 1'b0);
        abort = 1'b1;
        tick();
        check("abort busy", 32'(busy), 32'(0));
        check("abort valid", 32'(addr_valid), 32'(0));
        check("abort done", 32'(done), 32'(0));
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort no done +%0d", i + 1), 32'({done, busy}), 32'(0));
        end
        // Restart; an abort held in IDLE alongside start must not block it.
        abort = 1'b1;
        start_run(m_head, DEPTH);
        watch_run("restart", DEPTH * NCH, 0, 1'b0);

        // cfg_we + start + smp_push in one IDLE cycle.
        smp_push = 1'b1;
        m_head   = m_head + 1'b1;
        cfg_we   = 1'b1;
        cfg_taps = 6'd3;
        start_run(m_head, 3);
        watch_run("simul", 3 * NCH, 2, 1'b0);
        // Mid-run: a push moves head only; start and cfg_we are ignored.
        smp_push = 1'b1;
        m_head   = m_head + 1'b1;
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_taps = 6'd5;
        watch_run("simul", 3 * NCH, 0, 1'b1);
        // Tap count must still be 3.
        start_run(m_head, 3);
        watch_run("taps kept", 3 * NCH, 0, 1'b0);

        // Asynchronous reset on RUN cycle 5.
        start_run(m_head, 3);
        watch_run("rst mid", 3 * NCH, 5, 1'b0);
        rst = 1'b1;
        #1;
        check("rst mid outputs", 32'({busy, addr_valid, coef_addr, smp_addr, ch, last, done, head}), 32'(0));
        #2;
        rst = 1'b0;
        sb_q.delete();
        m_head = '0;
        // Start on the first edge after reset; tap count is back to DEPTH.
        start_run(m_head, DEPTH);
        watch_run("after rst", DEPTH * NCH, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
